// File: rtl/branch_unit.sv
// Branch resolution: evaluates the selected P flag and registers the decision.
// Define BRANCH_UNIT_PREG_EN to evaluate against a registered copy of P.
module branch_unit #(
  parameter logic [7:0] TAKEN_STATE     = 8'd63,
  parameter logic [7:0] NOT_TAKEN_STATE = 8'd0
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [7:0] p,
  input  logic       p_we,
  input  logic [7:0] op_flags,
  input  logic       branch_polarity,
  output logic       branch_taken,
  output logic [7:0] next_state_branch
);

  logic [7:0] w_p_src;
  logic       w_cond;
  logic       w_taken;
  logic [7:0] w_ns;

`ifdef BRANCH_UNIT_PREG_EN
  logic [7:0] r_p_q;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_p_q <= 8'h00;
    end else if (p_we) begin
      r_p_q <= p;
    end
  end

  assign w_p_src = r_p_q;
`else
  // Without the P copy the write enable has no effect.
  logic w_unused_p_we;
  assign w_unused_p_we = p_we;
  assign w_p_src       = p;
`endif

  assign w_cond  = |(w_p_src & op_flags);
  assign w_taken = w_cond ^ branch_polarity;
  assign w_ns    = w_taken ? TAKEN_STATE
                           : NOT_TAKEN_STATE;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      branch_taken      <= 1'b0;
      next_state_branch <= NOT_TAKEN_STATE;
    end else begin
      branch_taken      <= w_taken;
      next_state_branch <= w_ns;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed cases plus random traffic vs a flag model.
// Follows BRANCH_UNIT_PREG_EN the same way the design does.
module tb_branch_unit;

`ifdef BRANCH_UNIT_PREG_EN
  localparam bit PREG = 1'b1;
`else
  localparam bit PREG = 1'b0;
`endif

  logic       ph1;
  logic       reset;
  logic [7:0] p;
  logic       p_we;
  logic [7:0] op_flags;
  logic       branch_polarity;
  logic       branch_taken;
  logic [7:0] next_state_branch;

  int n_tests;
  int n_fail;

  logic [7:0] m_pq;

  branch_unit dut (
    .ph1              (ph1),
    .reset            (reset),
    .p                (p),
    .p_we             (p_we),
    .op_flags         (op_flags),
    .branch_polarity  (branch_polarity),
    .branch_taken     (branch_taken),
    .next_state_branch(next_state_branch)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Taken when any selected flag is set, inverted for branch-if-clear.
  function automatic bit ref_taken(input logic [7:0] ps,
                                   input logic [7:0] fl,
                                   input logic pol);
    bit any;
    any = 1'b0;
    for (int i = 0; i < 8; i++)
      if (fl[i] == 1'b1 && ps[i] == 1'b1) any = 1'b1;
    return pol ? !any : any;
  endfunction

  task automatic cyc(input string tag,
                     input logic [7:0] ip,
                     input logic iwe,
                     input logic [7:0] ifl,
                     input logic ipol);
    logic [7:0] src;
    bit e_tk;
    logic [7:0] e_ns;
    p = ip;
    p_we = iwe;
    op_flags = ifl;
    branch_polarity = ipol;
    src = PREG ? m_pq : ip;
    e_tk = ref_taken(src, ifl, ipol);
    e_ns = e_tk ? 8'd63 : 8'd0;
    if (PREG && iwe) m_pq = ip;
    @(posedge ph1);
    #1;
    check({tag, ".taken"}, {31'd0, branch_taken}, {31'd0, e_tk});
    check({tag, ".ns"}, {24'd0, next_state_branch}, {24'd0, e_ns});
  endtask

  initial begin
    logic [7:0] mk;
    n_tests = 0;
    n_fail = 0;
    m_pq = 8'h00;
    reset = 1'b1;
    p = 8'h00;
    p_we = 1'b0;
    op_flags = 8'h00;
    branch_polarity = 1'b0;
    repeat (2) @(posedge ph1);
    #1;
    check("rst.taken", {31'd0, branch_taken}, 32'd0);
    check("rst.ns", {24'd0, next_state_branch}, 32'd0);
    @(negedge ph1);
    reset = 1'b0;

    // BEQ taken
    cyc("beq_ld", 8'h02, 1'b1, 8'h00, 1'b0);
    cyc("beq", 8'h02, 1'b0, 8'h02, 1'b0);
    // BNE not taken, then Z cleared
    cyc("bne", 8'h02, 1'b0, 8'h02, 1'b1);
    cyc("bne_ld", 8'h00, 1'b1, 8'h02, 1'b1);
    cyc("bne2", 8'h00, 1'b0, 8'h02, 1'b1);

    // Flag sweep: C Z V N x polarity x set/clear
    for (int f = 0; f < 4; f++) begin
      case (f)
        0: mk = 8'h01;
        1: mk = 8'h02;
        2: mk = 8'h40;
        default: mk = 8'h80;
      endcase
      for (int s = 0; s < 2; s++)
        for (int pl = 0; pl < 2; pl++) begin
          cyc("swp_ld", s[0] ? mk : 8'h00, 1'b1,
              8'h00, 1'b0);
          cyc("sweep", s[0] ? mk : 8'h00, 1'b0,
              mk, pl[0]);
        end
    end

    // Edge cases
    cyc("zmask", 8'hff, 1'b0, 8'h00, 1'b1);
    cyc("multi_ld", 8'h40, 1'b1, 8'h00, 1'b0);
    cyc("multi", 8'h40, 1'b0, 8'hc3, 1'b0);
    cyc("pz_ld", 8'h00, 1'b1, 8'h00, 1'b0);
    cyc("pzero", 8'h00, 1'b0, 8'hff, 1'b0);
    cyc("b5_ld", 8'h20, 1'b1, 8'h00, 1'b0);
    cyc("bit5", 8'h20, 1'b0, 8'h20, 1'b0);

    // Same-edge capture and evaluation
    cyc("se_ld", 8'h02, 1'b1, 8'h00, 1'b0);
    cyc("same", 8'h00, 1'b1, 8'h02, 1'b0);
    cyc("same2", 8'h00, 1'b0, 8'h02, 1'b0);

    // Asynchronous reset mid-cycle with outputs at taken
    cyc("pre_rst", 8'h00, 1'b0, 8'h00, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("arst.taken", {31'd0, branch_taken}, 32'd0);
    check("arst.ns", {24'd0, next_state_branch}, 32'd0);
    @(posedge ph1);
    #1;
    check("hold.taken", {31'd0, branch_taken}, 32'd0);
    check("hold.ns", {24'd0, next_state_branch}, 32'd0);
    m_pq = 8'h00;
    @(negedge ph1);
    reset = 1'b0;
    cyc("post_rst", 8'h00, 1'b0, 8'h01, 1'b0);

    // Random traffic, mostly one-hot masks
    for (int i = 0; i < 300; i++) begin
      logic [7:0] rf;
      if ($urandom_range(3) == 0) rf = 8'($urandom);
      else rf = 8'(1 << $urandom_range(7));
      cyc("rand", 8'($urandom), 1'($urandom), rf,
          1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
